// File: rtl/ppu_pixel_fifo_mixer.sv
// Background/sprite pixel FIFO with sprite overlay, fine-scroll discard and palette mapping.
// Slots live in flops so a single flush can clear every sprite field at once.
module ppu_pixel_fifo_mixer #(
  parameter int DEPTH   = 16,
  parameter int TILE_W  = 8,
  parameter int BPP     = 2,
  parameter int NUM_OBP = 2,
  localparam int FXW  = (TILE_W > 1) ? $clog2(TILE_W) : 1,
  localparam int PSW  = (NUM_OBP > 1) ? $clog2(NUM_OBP) : 1,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PALW = BPP << BPP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [FXW-1:0]            fine_x,
  input  logic                      bg_valid,
  output logic                      bg_ready,
  input  logic [BPP*TILE_W-1:0]     bg_planes,
  input  logic                      sp_valid,
  output logic                      sp_ready,
  input  logic [BPP*TILE_W-1:0]     sp_planes,
  input  logic [PSW-1:0]            sp_pal,
  input  logic                      sp_behind,
  input  logic                      bg_en,
  input  logic                      sp_en,
  input  logic [PALW-1:0]           bgp,
  input  logic [NUM_OBP*PALW-1:0]   obp,
  input  logic                      pop_en,
  output logic [BPP-1:0]            px_out,
  output logic                      px_valid,
  output logic [CW-1:0]             count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FXW-1:0] disc_q, disc_d;
  logic [BPP-1:0] px_out_q, px_out_d;
  logic           px_valid_q, px_valid_d;
  logic           pop_fire, load, merge;

  logic [BPP-1:0] slot_bg [DEPTH];
  logic [BPP-1:0] slot_sp [DEPTH];
  logic [PSW-1:0] slot_pal [DEPTH];
  logic           slot_beh [DEPTH];

  assign pop_fire = !flush && (count_q != '0) && ((disc_q != '0) || pop_en);
  assign bg_ready = !rst && !flush && (count_q <= CW'(DEPTH - TILE_W));
  assign sp_ready = !rst && !flush && (count_q >= CW'(TILE_W)) && !pop_fire;
  assign load     = bg_valid && bg_ready;
  assign merge    = sp_valid && sp_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [BPP-1:0] bg_c_q, bg_c_d, sp_c_q, sp_c_d, new_bg, new_sp;
    logic [PSW-1:0] sp_pal_q, sp_pal_d;
    logic           sp_behind_q, sp_behind_d;
    int             ld_off, mg_off;

    always_comb begin
      // Offsets of this slot from the write and read pointers, modulo DEPTH.
      ld_off = gi - int'(wr_ptr_q);
      if (ld_off < 0) ld_off = ld_off + DEPTH;
      mg_off = gi - int'(rd_ptr_q);
      if (mg_off < 0) mg_off = mg_off + DEPTH;
      new_bg = '0;
      new_sp = '0;
      for (int b = 0; b < BPP; b++) begin
        if (ld_off < TILE_W) new_bg[b] = bg_planes[b*TILE_W + TILE_W-1-ld_off];
        if (mg_off < TILE_W) new_sp[b] = sp_planes[b*TILE_W + TILE_W-1-mg_off];
      end
      bg_c_d      = bg_c_q;
      sp_c_d      = sp_c_q;
      sp_pal_d    = sp_pal_q;
      sp_behind_d = sp_behind_q;
      if (flush) begin
        sp_c_d      = '0;
        sp_pal_d    = '0;
        sp_behind_d = 1'b0;
      end else begin
        if (load && ld_off < TILE_W) begin
          bg_c_d      = new_bg;
          sp_c_d      = '0;
          sp_pal_d    = '0;
          sp_behind_d = 1'b0;
        end
        // An already-occupied sprite pixel keeps priority over later sprites.
        if (merge && mg_off < TILE_W && new_sp != '0 && sp_c_q == '0) begin
          sp_c_d      = new_sp;
          sp_pal_d    = sp_pal;
          sp_behind_d = sp_behind;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bg_c_q      <= '0;
        sp_c_q      <= '0;
        sp_pal_q    <= '0;
        sp_behind_q <= 1'b0;
      end else begin
        bg_c_q      <= bg_c_d;
        sp_c_q      <= sp_c_d;
        sp_pal_q    <= sp_pal_d;
        sp_behind_q <= sp_behind_d;
      end
    end

    assign slot_bg[gi]  = bg_c_q;
    assign slot_sp[gi]  = sp_c_q;
    assign slot_pal[gi] = sp_pal_q;
    assign slot_beh[gi] = sp_behind_q;
  end

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  logic [BPP-1:0] head_bg, head_sp, b_eff, mix_px;
  logic [PSW-1:0] head_pal;
  logic           head_beh, sprite_win;

  always_comb begin
    head_bg    = slot_bg[rd_ptr_q];
    head_sp    = slot_sp[rd_ptr_q];
    head_pal   = slot_pal[rd_ptr_q];
    head_beh   = slot_beh[rd_ptr_q];
    b_eff      = bg_en ? head_bg : '0;
    sprite_win = sp_en && (head_sp != '0) && !(head_beh && (b_eff != '0));
    mix_px     = sprite_win ? obp[int'(head_pal)*PALW + int'(head_sp)*BPP +: BPP]
                            : bgp[int'(b_eff)*BPP +: BPP];
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    disc_d     = disc_q;
    px_out_d   = px_out_q;
    px_valid_d = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      disc_d   = fine_x;
    end else begin
      if (pop_fire) begin
        rd_ptr_d = ptr_add(rd_ptr_q, 1);
        if (disc_q != '0) begin
          disc_d = disc_q - 1'b1;
        end else begin
          px_valid_d = 1'b1;
          px_out_d   = mix_px;
        end
      end
      if (load) wr_ptr_d = ptr_add(wr_ptr_q, TILE_W);
      count_d = CW'(int'(count_q) + (load ? TILE_W : 0) - (pop_fire ? 1 : 0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      disc_q     <= '0;
      px_out_q   <= '0;
      px_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      disc_q     <= disc_d;
      px_out_q   <= px_out_d;
      px_valid_q <= px_valid_d;
    end
  end

  assign px_out   = px_out_q;
  assign px_valid = px_valid_q;
  assign count    = count_q;
endmodule

// File: tb/tb_ppu_pixel_fifo_mixer.sv
// Bench for ppu_pixel_fifo_mixer: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_ppu_pixel_fifo_mixer;
  localparam int DEPTH = 16, TILE_W = 8, BPP = 2, NUM_OBP = 2;

  logic        clk, rst, flush, bg_valid, bg_ready, sp_valid, sp_ready;
  logic [2:0]  fine_x;
  logic [15:0] bg_planes, sp_planes;
  logic        sp_pal, sp_behind, bg_en, sp_en, pop_en, px_valid;
  logic [7:0]  bgp;
  logic [15:0] obp;
  logic [1:0]  px_out;
  logic [4:0]  count;

  ppu_pixel_fifo_mixer #(.DEPTH(DEPTH), .TILE_W(TILE_W), .BPP(BPP), .NUM_OBP(NUM_OBP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fine_x(fine_x),
    .bg_valid(bg_valid), .bg_ready(bg_ready), .bg_planes(bg_planes),
    .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_planes(sp_planes),
    .sp_pal(sp_pal), .sp_behind(sp_behind), .bg_en(bg_en), .sp_en(sp_en),
    .bgp(bgp), .obp(obp), .pop_en(pop_en),
    .px_out(px_out), .px_valid(px_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue of pixel records, head at index 0.
  typedef struct { logic [1:0] bg; logic [1:0] sp; logic pal; logic beh; } slot_t;
  slot_t      mq[$];
  int         m_disc;
  logic       m_valid;
  logic [1:0] m_px;

  function automatic bit m_pop();
    return !flush && mq.size() > 0 && (m_disc > 0 || pop_en);
  endfunction
  function automatic bit m_bgr();
    return !flush && mq.size() <= DEPTH - TILE_W;
  endfunction
  function automatic bit m_spr();
    return !flush && mq.size() >= TILE_W && !m_pop();
  endfunction

  function automatic logic [1:0] m_mix(input slot_t s);
    int b;
    b = bg_en ? int'(s.bg) : 0;
    if (sp_en && s.sp != 0 && !(s.beh && b != 0))
      return 2'((obp >> (int'(s.pal) * 8 + int'(s.sp) * 2)) & 16'd3);
    return 2'((bgp >> (b * 2)) & 8'd3);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_disc  = 0;
    m_valid = 1'b0;
    m_px    = 2'd0;
  endtask

  task automatic model_edge();
    bit ld, pp, mg;
    slot_t s;
    logic [1:0] c;
    if (flush) begin
      mq.delete();
      m_disc  = int'(fine_x);
      m_valid = 1'b0;
      return;
    end
    ld = bg_valid && m_bgr();
    pp = m_pop();
    mg = sp_valid && m_spr();
    m_valid = 1'b0;
    if (mg)
      for (int i = 0; i < TILE_W; i++) begin
        c = {sp_planes[TILE_W + 7 - i], sp_planes[7 - i]};
        if (c != 0 && mq[i].sp == 0) begin
          mq[i].sp  = c;
          mq[i].pal = sp_pal;
          mq[i].beh = sp_behind;
        end
      end
    if (pp) begin
      s = mq.pop_front();
      if (m_disc > 0) m_disc--;
      else begin
        m_valid = 1'b1;
        m_px    = m_mix(s);
      end
    end
    if (ld)
      for (int i = 0; i < TILE_W; i++) begin
        s.bg  = {bg_planes[TILE_W + 7 - i], bg_planes[7 - i]};
        s.sp  = 2'd0;
        s.pal = 1'b0;
        s.beh = 1'b0;
        mq.push_back(s);
      end
  endtask

  // One clock: check handshakes before the edge, registered outputs after it.
  task automatic step();
    #1;
    chk("bg_ready", bg_ready, m_bgr());
    chk("sp_ready", sp_ready, m_spr());
    @(posedge clk);
    model_edge();
    #1;
    chk("count", count, mq.size());
    chk("px_valid", px_valid, m_valid);
    if (m_valid) chk("px_out", px_out, m_px);
  endtask

  task automatic idle();
    flush = 0; fine_x = 0; bg_valid = 0; sp_valid = 0; pop_en = 0;
    bg_planes = 0; sp_planes = 0; sp_pal = 0; sp_behind = 0;
  endtask

  task automatic do_flush(input logic [2:0] fx);
    idle(); flush = 1; fine_x = fx; step(); flush = 0;
  endtask
  task automatic do_load(input logic [7:0] lo, input logic [7:0] hi);
    idle(); bg_valid = 1; bg_planes = {hi, lo}; step(); bg_valid = 0;
  endtask
  task automatic do_merge(input logic [7:0] lo, input logic [7:0] hi, input logic pal, input logic beh);
    idle(); sp_valid = 1; sp_planes = {hi, lo}; sp_pal = pal; sp_behind = beh; step(); sp_valid = 0;
  endtask
  task automatic pop_expect(input string name, input logic [1:0] e);
    idle(); pop_en = 1; step(); pop_en = 0;
    chk({name, "_valid"}, px_valid, 1);
    chk(name, px_out, e);
  endtask

  typedef struct {
    logic flush; logic [2:0] fx; logic bgv; logic [7:0] lo, hi; logic pop;
    logic exp_bgr; int exp_cnt; logic exp_v; logic [1:0] exp_px;
  } vec_t;
  vec_t tbl[23];

  initial begin
    // flush fx3, load lo=FF: 3 discards then five pixels of 1
    tbl[0]  = '{1, 3, 0, 8'h00, 8'h00, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 0, 1, 8'hFF, 8'h00, 1, 1,  8, 0, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  7, 0, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  6, 0, 0};
    tbl[4]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  5, 0, 0};
    tbl[5]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  4, 1, 1};
    tbl[6]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  3, 1, 1};
    tbl[7]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  2, 1, 1};
    tbl[8]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  1, 1, 1};
    tbl[9]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  0, 1, 1};
    tbl[10] = '{0, 0, 0, 8'h00, 8'h00, 1, 1,  0, 0, 0};
    // fill to 16, bg_ready drops until count is back at 8
    tbl[11] = '{0, 0, 1, 8'h0F, 8'h33, 0, 1,  8, 0, 0};
    tbl[12] = '{0, 0, 1, 8'h0F, 8'h33, 0, 1, 16, 0, 0};
    tbl[13] = '{0, 0, 1, 8'h0F, 8'h33, 1, 0, 15, 1, 0};
    tbl[14] = '{0, 0, 1, 8'h0F, 8'h33, 1, 0, 14, 1, 0};
    tbl[15] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 13, 1, 2};
    tbl[16] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 12, 1, 2};
    tbl[17] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 11, 1, 1};
    tbl[18] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 10, 1, 1};
    tbl[19] = '{0, 0, 0, 8'h00, 8'h00, 1, 0,  9, 1, 3};
    tbl[20] = '{0, 0, 0, 8'h00, 8'h00, 1, 0,  8, 1, 3};
    tbl[21] = '{0, 0, 0, 8'h00, 8'h00, 0, 1,  8, 0, 0};
    tbl[22] = '{1, 0, 0, 8'h00, 8'h00, 0, 0,  0, 0, 0};

    rst = 1; idle(); bg_en = 1; sp_en = 1; bgp = 8'hE4; obp = {8'h39, 8'hE4};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_out", px_out, 0);
    chk("rst_bg_ready", bg_ready, 0);
    chk("rst_sp_ready", sp_ready, 0);
    rst = 0;

    for (int i = 0; i < 23; i++) begin
      idle();
      flush = tbl[i].flush; fine_x = tbl[i].fx; bg_valid = tbl[i].bgv;
      bg_planes = {tbl[i].hi, tbl[i].lo}; pop_en = tbl[i].pop;
      #1;
      chk($sformatf("vec%0d_bg_ready", i), bg_ready, tbl[i].exp_bgr);
      step();
      chk($sformatf("vec%0d_count", i), count, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_px_valid", i), px_valid, tbl[i].exp_v);
      if (tbl[i].exp_v) chk($sformatf("vec%0d_px_out", i), px_out, tbl[i].exp_px);
    end

    // Sprite behind non-zero background, then in front of it
    do_flush(0); do_load(8'hFF, 8'hFF); do_merge(8'hF0, 8'h00, 1, 1);
    for (int i = 0; i < 8; i++) pop_expect("merge_behind", 2'd3);
    do_flush(0); do_load(8'hFF, 8'hFF); do_merge(8'hF0, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) pop_expect("merge_front", (i < 4) ? 2'd2 : 2'd3);

    // Earlier sprite keeps its pixels when a second one overlaps
    do_flush(0); do_load(8'h00, 8'h00);
    do_merge(8'hF0, 8'h00, 0, 0); do_merge(8'hFF, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++) pop_expect("overlap", (i < 4) ? 2'd1 : 2'd2);

    // Sprite held off while the head is being popped
    do_flush(0); do_load(8'h00, 8'h00); do_load(8'h00, 8'h00);
    idle(); sp_valid = 1; sp_planes = {8'h00, 8'hF0}; sp_pal = 1; pop_en = 1;
    for (int i = 0; i < 2; i++) begin
      #1; chk("stall_sp_ready", sp_ready, 0);
      step();
    end
    pop_en = 0;
    #1; chk("stall_release_sp_ready", sp_ready, 1);
    step();
    chk("stall_count", count, 14);
    for (int i = 0; i < 8; i++) pop_expect("stall_merge", (i < 4) ? 2'd2 : 2'd0);

    // Asynchronous reset in the middle of a line with 12 pixels queued
    do_flush(0); do_load(8'h5A, 8'hC3); do_load(8'h5A, 8'hC3);
    idle(); pop_en = 1;
    repeat (4) step();
    chk("pre_rst_count", count, 12);
    idle();
    #2 rst = 1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_px_valid", px_valid, 0);
    chk("async_rst_bg_ready", bg_ready, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;
    step();
    chk("post_rst_bg_ready", bg_ready, 1);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom_range(0, 49) == 0);
      fine_x    = 3'($urandom_range(0, 7));
      bg_valid  = $urandom_range(0, 1);
      bg_planes = 16'($urandom);
      sp_valid  = ($urandom_range(0, 2) == 0);
      sp_planes = 16'($urandom);
      sp_pal    = $urandom_range(0, 1);
      sp_behind = $urandom_range(0, 1);
      bg_en     = ($urandom_range(0, 7) != 0);
      sp_en     = ($urandom_range(0, 7) != 0);
      pop_en    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bgp = 8'($urandom);
        obp = 16'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
